dvi_pixel_stage: RTL

//  Output pixel stage between the 1280x720 timing generator / frame reader and the DVI_TX_Top encoders.

---
 rtl/dvi_pixel_stage.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/dvi_pixel_stage.sv
// dvi_pixel_stage: last pixel stage in front of the DVI transmitters.
// Realigns hs/vs/de with the frame reader's delayed data. Expands RGB565 to
// RGB888 and overlays a per-camera identification border. Tracks per-frame
// valid-pixel statistics and substitutes a flat colour when video is lost.
module dvi_pixel_stage #(
  parameter int          SYNC_DLY     = 2,
  parameter int          H_ACTIVE     = 1280,
  parameter int          V_ACTIVE     = 720,
  parameter int          BORDER_W     = 4,
  parameter int          NOSIG_FRAMES = 2,
  parameter logic [23:0] NOSIG_COLOR  = 24'h404040
) (
  input  logic        video_clk,
  input  logic        rst_n,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        de_in,
  input  logic        pix_de,
  input  logic [15:0] pix_data,
  input  logic        border_en,
  input  logic [1:0]  cam_sel,
  output logic        rgb_hs,
  output logic        rgb_vs,
  output logic        rgb_de,
  output logic [7:0]  rgb_r,
  output logic [7:0]  rgb_g,
  output logic [7:0]  rgb_b,
  output logic        nosig,
  output logic [15:0] underflow_cnt
);

  localparam int PIX_TOTAL = H_ACTIVE * V_ACTIVE;
  // One spare bit so an over-long frame saturates above the full count
  // instead of wrapping onto it.
  localparam int VCNT_W = $clog2(PIX_TOTAL + 1) + 1;
  localparam logic [VCNT_W-1:0] VCNT_FULL   = VCNT_W'(PIX_TOTAL);
  localparam logic [10:0]       X_LO        = 11'(BORDER_W);
  localparam logic [10:0]       X_HI        = 11'(H_ACTIVE - BORDER_W);
  localparam logic [9:0]        Y_LO        = 10'(BORDER_W);
  localparam logic [9:0]        Y_HI        = 10'(V_ACTIVE - BORDER_W);
  localparam logic [3:0]        EMPTY_LIMIT = 4'(NOSIG_FRAMES);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_LOCKED = 2'd1,
    ST_NOSIG  = 2'd2
  } state_e;

  logic [SYNC_DLY-1:0] hs_sr_q, vs_sr_q, de_sr_q;
  logic                d_hs_s, d_vs_s, d_de_s;
  logic                d_vs_prev_q, d_de_prev_q;
  logic                frame_end_s, line_end_s;
  logic [10:0]         x_q;
  logic [9:0]          y_q;
  logic                in_border_s;
  logic [VCNT_W-1:0]   vcnt_q;
  logic                seen_q, full_s;
  logic                ben_q;
  logic [1:0]          cam_q;
  logic [23:0]         cam_rgb_s, col_d;
  logic [15:0]         uf_q;
  state_e              state_q, state_d;
  logic [3:0]          empty_q, empty_d, empty_inc_s;
  logic                hs_q, vs_q, de_q, nosig_q;
  logic [23:0]         rgb_q;

  assign d_hs_s      = hs_sr_q[SYNC_DLY-1];
  assign d_vs_s      = vs_sr_q[SYNC_DLY-1];
  assign d_de_s      = de_sr_q[SYNC_DLY-1];
  assign frame_end_s = d_vs_s & ~d_vs_prev_q;
  assign line_end_s  = ~d_de_s & d_de_prev_q;
  assign in_border_s = (x_q < X_LO) | (x_q >= X_HI) | (y_q < Y_LO) | (y_q >= Y_HI);
  assign full_s      = (vcnt_q == VCNT_FULL);
  assign empty_inc_s = empty_q + 4'd1;

  // Sync delay line: hold hs/vs/de until the matching reader data arrives.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr_q     <= '0;
      vs_sr_q     <= '0;
      de_sr_q     <= '0;
      d_vs_prev_q <= 1'b0;
      d_de_prev_q <= 1'b0;
    end else begin
      hs_sr_q     <= SYNC_DLY'({hs_sr_q, hs_in});
      vs_sr_q     <= SYNC_DLY'({vs_sr_q, vs_in});
      de_sr_q     <= SYNC_DLY'({de_sr_q, de_in});
      d_vs_prev_q <= d_vs_s;
      d_de_prev_q <= d_de_s;
    end
  end

  // Pixel position, counted on the delayed data enable.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= 11'd0;
      y_q <= 10'd0;
    end else begin
      if (d_de_s)          x_q <= x_q + 11'd1;
      else if (line_end_s) x_q <= 11'd0;
      if (frame_end_s)     y_q <= 10'd0;
      else if (line_end_s) y_q <= y_q + 10'd1;
    end
  end

  // Frame statistics and once-per-frame sampling of the border settings.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      vcnt_q <= '0;
      seen_q <= 1'b0;
      ben_q  <= 1'b0;
      cam_q  <= 2'd0;
      uf_q   <= 16'd0;
    end else begin
      if (frame_end_s) begin
        vcnt_q <= '0;
        seen_q <= 1'b0;
        ben_q  <= border_en;
        cam_q  <= cam_sel;
      end else if (d_de_s & pix_de) begin
        seen_q <= 1'b1;
        if (vcnt_q != {VCNT_W{1'b1}}) vcnt_q <= vcnt_q + 1'b1;
      end
      if (d_de_s & ~pix_de & (uf_q != 16'hFFFF)) uf_q <= uf_q + 16'd1;
    end
  end

  // Signal-presence state register.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_SEARCH;
      empty_q <= 4'd0;
    end else begin
      state_q <= state_d;
      empty_q <= empty_d;
    end
  end

  // Signal-presence next state, evaluated only at the frame-end edge.
  always_comb begin
    state_d = state_q;
    empty_d = empty_q;
    if (frame_end_s) begin
      case (state_q)
        ST_SEARCH: begin
          if (full_s) begin
            state_d = ST_LOCKED;
            empty_d = 4'd0;
          end else if (!seen_q) begin
            empty_d = empty_inc_s;
            if (empty_inc_s == EMPTY_LIMIT) state_d = ST_NOSIG;
            else                            state_d = ST_SEARCH;
          end else begin
            empty_d = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!seen_q) begin
            empty_d = 4'd1;
            if (EMPTY_LIMIT == 4'd1) state_d = ST_NOSIG;
            else                     state_d = ST_SEARCH;
          end else begin
            state_d = ST_LOCKED;
          end
        end
        ST_NOSIG: begin
          if (full_s) begin
            state_d = ST_LOCKED;
            empty_d = 4'd0;
          end else if (seen_q) begin
            state_d = ST_SEARCH;
            empty_d = 4'd0;
          end else begin
            state_d = ST_NOSIG;
          end
        end
        default: begin
          state_d = ST_SEARCH;
          empty_d = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
      empty_d = empty_q;
    end
  end

  // Camera identification colour for the latched camera.
  always_comb begin
    cam_rgb_s = 24'h000000;
    case (cam_q)
      2'd0:    cam_rgb_s = 24'hFF0000;
      2'd1:    cam_rgb_s = 24'h00FF00;
      2'd2:    cam_rgb_s = 24'h0000FF;
      default: cam_rgb_s = 24'hFFFFFF;
    endcase
  end

  // Output colour selection: blanking, no-signal fill, border, underflow, pixel.
  always_comb begin
    col_d = 24'h000000;
    if (!d_de_s) begin
      col_d = 24'h000000;
    end else if (state_q == ST_NOSIG) begin
      col_d = NOSIG_COLOR;
    end else if (ben_q & in_border_s) begin
      col_d = cam_rgb_s;
    end else if (!pix_de) begin
      col_d = 24'h000000;
    end else begin
      col_d = {pix_data[15:11], pix_data[15:13],
               pix_data[10:5],  pix_data[10:9],
               pix_data[4:0],   pix_data[4:2]};
    end
  end

  // Output register: syncs and colour leave together.
  always_ff @(posedge video_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      de_q    <= 1'b0;
      rgb_q   <= 24'h000000;
      nosig_q <= 1'b0;
    end else begin
      hs_q    <= d_hs_s;
      vs_q    <= d_vs_s;
      de_q    <= d_de_s;
      rgb_q   <= col_d;
      nosig_q <= (state_d == ST_NOSIG);
    end
  end

  assign rgb_hs        = hs_q;
  assign rgb_vs        = vs_q;
  assign rgb_de        = de_q;
  assign rgb_r         = rgb_q[23:16];
  assign rgb_g         = rgb_q[15:8];
  assign rgb_b         = rgb_q[7:0];
  assign nosig         = nosig_q;
  assign underflow_cnt = uf_q;

endmodule
